// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
//   Shared constants for the Avalon-MM GPIO bank: word offsets of the
//   register map, used by the RTL and by anything that drives the bus.
//   No ports.
package gpio_bank_pkg;

   localparam logic [2:0] ADDR_DATA_IN  = 3'd0;  // RO, debounced inputs
   localparam logic [2:0] ADDR_DATA_OUT = 3'd1;  // RW, output latch
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;  // RW
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;  // R, write-1-to-clear
   localparam logic [2:0] ADDR_RISE_EN  = 3'd4;  // RW
   localparam logic [2:0] ADDR_FALL_EN  = 3'd5;  // RW
   localparam logic [2:0] ADDR_OUT_SET  = 3'd6;  // WO, 1 bits set DATA_OUT
   localparam logic [2:0] ADDR_OUT_CLR  = 3'd7;  // WO, 1 bits clear DATA_OUT

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   One GPIO input bit: 2-flop synchroniser followed by a debounce filter.
//   The debounced value follows the synchronised value only after the two
//   have disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreeing
//   cycle restarts the count. DEBOUNCE_CYCLES = 0 bypasses the filter.
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_async      raw asynchronous input
//   o_debounced  debounced level
module gpio_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_debounced
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign o_debounced = r_sync;
      end else begin : g_filter
         localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
         // Counter holds the number of disagreeing cycles already seen, so
         // the update happens on the cycle the count would reach
         // DEBOUNCE_CYCLES; it never goes past DEBOUNCE_CYCLES-1.
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] r_cnt;
         logic             r_deb;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_cnt <= '0;
               r_deb <= 1'b0;
            end else if (r_sync == r_deb) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_deb <= r_sync;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end

         assign o_debounced = r_deb;
      end
   endgenerate

endmodule

// File: rtl/avmm_gpio_bank.sv
// avmm_gpio_bank
//   Avalon-MM slave GPIO bank: debounced inputs with per-bit rise/fall edge
//   capture and maskable level interrupt, plus a registered output latch
//   with set/clear aliases. Read latency is fixed at one cycle.
// Ports
//   clk_clk        clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   avs_address    word register index (see gpio_bank_pkg)
//   avs_read       read strobe
//   avs_write      write strobe
//   avs_writedata  write data (bits 31..WIDTH ignored)
//   avs_readdata   read data, valid the cycle after avs_read
//   irq            registered level interrupt
//   gpio_in        asynchronous external inputs
//   gpio_out       registered outputs
module avmm_gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] OUT_RESET       = '0
)(
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out
);

   logic [WIDTH-1:0] r_data_out;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_cap;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [WIDTH-1:0] r_deb_prev;
   logic             r_irq;
   logic [31:0]      r_readdata;

   logic [WIDTH-1:0] w_deb;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_rd_sel;
   logic [31:0]      w_rd_word;
   logic [31:0]      w_unused_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         gpio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .i_clk       (clk_clk),
            .i_rst_n     (reset_reset_n),
            .i_async     (gpio_in[gi]),
            .o_debounced (w_deb[gi])
         );
      end
   endgenerate

   // Upper write-data bits are architecturally ignored.
   assign w_unused_wdata = avs_writedata;
   assign w_wdata        = avs_writedata[WIDTH-1:0];

   assign w_edge = (w_deb & ~r_deb_prev & r_rise_en) |
                   (~w_deb & r_deb_prev & r_fall_en);
   assign w_clr  = (avs_write && avs_address == ADDR_EDGE_CAP) ? w_wdata : '0;

   always_comb begin
      w_rd_sel = '0;
      case (avs_address)
         ADDR_DATA_IN:  w_rd_sel = w_deb;
         ADDR_DATA_OUT: w_rd_sel = r_data_out;
         ADDR_IRQ_MASK: w_rd_sel = r_irq_mask;
         ADDR_EDGE_CAP: w_rd_sel = r_edge_cap;
         ADDR_RISE_EN:  w_rd_sel = r_rise_en;
         ADDR_FALL_EN:  w_rd_sel = r_fall_en;
         default:       w_rd_sel = '0;   // OUT_SET / OUT_CLR are write-only
      endcase
      w_rd_word              = '0;
      w_rd_word[WIDTH-1:0]   = w_rd_sel;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_data_out <= OUT_RESET;
         r_irq_mask <= '0;
         r_edge_cap <= '0;
         r_rise_en  <= '0;
         r_fall_en  <= '0;
         r_deb_prev <= '0;
         r_irq      <= 1'b0;
         r_readdata <= '0;
      end else begin
         r_deb_prev <= w_deb;
         // A fresh edge overrides a same-cycle write-1-to-clear.
         r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
         r_irq      <= |(r_edge_cap & r_irq_mask);
         // Read data is taken from the pre-write register contents.
         if (avs_read) begin
            r_readdata <= w_rd_word;
         end
         if (avs_write) begin
            case (avs_address)
               ADDR_DATA_OUT: r_data_out <= w_wdata;
               ADDR_IRQ_MASK: r_irq_mask <= w_wdata;
               ADDR_RISE_EN:  r_rise_en  <= w_wdata;
               ADDR_FALL_EN:  r_fall_en  <= w_wdata;
               ADDR_OUT_SET:  r_data_out <= r_data_out | w_wdata;
               ADDR_OUT_CLR:  r_data_out <= r_data_out & ~w_wdata;
               default:       ;
            endcase
         end
      end
   end

   assign gpio_out     = r_data_out;
   assign avs_readdata = r_readdata;
   assign irq          = r_irq;

endmodule

// File: tb/tb_avmm_gpio_bank.sv
// tb_avmm_gpio_bank
//   Directed bench for avmm_gpio_bank. Main instance: WIDTH=8,
//   DEBOUNCE_CYCLES=4, OUT_RESET=0x5A. Second instance: WIDTH=2,
//   DEBOUNCE_CYCLES=0, OUT_RESET=0x1. Read expectations for the main
//   instance go into a queue and are checked by a separate monitor.
module tb_avmm_gpio_bank;
   import gpio_bank_pkg::*;

   logic        clk;
   logic        rst_n;

   logic [2:0]  m_addr;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_irq;
   logic [7:0]  m_gin;
   logic [7:0]  m_gout;

   logic [2:0]  s_addr;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata;
   logic        s_irq;
   logic [1:0]  s_gin;
   logic [1:0]  s_gout;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   avmm_gpio_bank #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4),
      .OUT_RESET       (8'h5A)
   ) u_dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .avs_address   (m_addr),
      .avs_read      (m_read),
      .avs_write     (m_write),
      .avs_writedata (m_wdata),
      .avs_readdata  (m_rdata),
      .irq           (m_irq),
      .gpio_in       (m_gin),
      .gpio_out      (m_gout)
   );

   avmm_gpio_bank #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (0),
      .OUT_RESET       (2'b01)
   ) u_dut_w2 (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .avs_address   (s_addr),
      .avs_read      (s_read),
      .avs_write     (s_write),
      .avs_writedata (s_wdata),
      .avs_readdata  (s_rdata),
      .irq           (s_irq),
      .gpio_in       (s_gin),
      .gpio_out      (s_gout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         n_pass++;
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_wr(input logic [2:0] a, input logic [31:0] d);
      m_addr  = a;
      m_wdata = d;
      m_write = 1'b1;
      @(posedge clk);
      #1;
      m_write = 1'b0;
   endtask

   task automatic m_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      m_addr = a;
      m_read = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      m_read = 1'b0;
   endtask

   task automatic m_rdwr(input logic [2:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input string name);
      m_addr  = a;
      m_wdata = d;
      m_read  = 1'b1;
      m_write = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      m_read  = 1'b0;
      m_write = 1'b0;
   endtask

   task automatic s_wr(input logic [2:0] a, input logic [31:0] d);
      s_addr  = a;
      s_wdata = d;
      s_write = 1'b1;
      @(posedge clk);
      #1;
      s_write = 1'b0;
   endtask

   task automatic s_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      s_addr = a;
      s_read = 1'b1;
      @(posedge clk);
      #1;
      s_read = 1'b0;
      chk(name, s_rdata, exp);
   endtask

   // Monitor: a read sampled on a rising edge presents data after that edge.
   initial begin
      forever begin
         @(posedge clk);
         if (m_read === 1'b1) begin
            #2;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL read_unexpected: got 0x%08h expected no read data", m_rdata);
            end else begin
               chk(name_q.pop_front(), m_rdata, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b1;
      m_addr  = '0; m_read = 1'b0; m_write = 1'b0; m_wdata = '0; m_gin = '0;
      s_addr  = '0; s_read = 1'b0; s_write = 1'b0; s_wdata = '0; s_gin = '0;
      #1 rst_n = 1'b0;
      #2;
      // Asynchronous reset: no clock edge has occurred yet.
      chk("rst_gpio_out",  32'(m_gout), 32'h5A);
      chk("rst_irq",       32'(m_irq), 32'h0);
      chk("rst_readdata",  m_rdata, 32'h0);
      chk("w2_rst_gpio_out", 32'(s_gout), 32'h1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      m_rd(ADDR_DATA_OUT, 32'h5A, "rst_data_out");
      m_rd(ADDR_IRQ_MASK, 32'h0,  "rst_irq_mask");
      m_rd(ADDR_EDGE_CAP, 32'h0,  "rst_edge_cap");
      m_rd(ADDR_RISE_EN,  32'h0,  "rst_rise_en");

      // Narrow instance: write-data truncation and bypass latency.
      s_wr(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
      s_rd(ADDR_IRQ_MASK, 32'h3, "w2_mask_trunc");
      s_wr(ADDR_OUT_SET, 32'hFFFF_FFFC);
      chk("w2_set_high_ignored", 32'(s_gout), 32'h1);
      s_gin = 2'b10;
      s_rd(ADDR_DATA_IN, 32'h0, "w2_bypass_e1");
      s_rd(ADDR_DATA_IN, 32'h0, "w2_bypass_e2");
      s_rd(ADDR_DATA_IN, 32'h2, "w2_bypass_e3");

      // Debounce latency: new value readable exactly 2+4+1 cycles on.
      m_gin[0] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         m_rd(ADDR_DATA_IN, (k == 7) ? 32'h1 : 32'h0, "deb_latency");
      end
      // Three-cycle glitch is rejected.
      m_gin[1] = 1'b1;
      tick(3);
      m_gin[1] = 1'b0;
      tick(10);
      m_rd(ADDR_DATA_IN, 32'h01, "glitch3_rejected");
      m_rd(ADDR_EDGE_CAP, 32'h0, "no_edge_rise_en0");
      // Four-cycle pulse is the shortest accepted one.
      m_wr(ADDR_RISE_EN, 32'h04);
      m_gin[2] = 1'b1;
      tick(4);
      m_gin[2] = 1'b0;
      tick(14);
      m_rd(ADDR_EDGE_CAP, 32'h04, "pulse4_captured");
      m_rd(ADDR_DATA_IN, 32'h01, "pulse4_settled");
      chk("irq_masked", 32'(m_irq), 32'h0);
      m_wr(ADDR_EDGE_CAP, 32'hFFFF_FFFF);
      m_rd(ADDR_EDGE_CAP, 32'h0, "w1c_all");

      // Rising edge -> EDGE_CAP -> irq, then clear.
      m_gin[0] = 1'b0;
      tick(10);
      m_wr(ADDR_RISE_EN, 32'h05);
      m_wr(ADDR_IRQ_MASK, 32'h01);
      m_gin[0] = 1'b1;
      tick(7);
      chk("irq_not_yet", 32'(m_irq), 32'h0);
      tick(1);
      chk("irq_on_rise", 32'(m_irq), 32'h1);
      m_rd(ADDR_EDGE_CAP, 32'h01, "edge_cap_rise");
      m_wr(ADDR_EDGE_CAP, 32'h01);
      chk("irq_w1c_lag", 32'(m_irq), 32'h1);
      tick(1);
      chk("irq_cleared", 32'(m_irq), 32'h0);

      // Edge in the same cycle as write-1-to-clear.
      m_wr(ADDR_FALL_EN, 32'h01);
      m_gin[0] = 1'b0;
      tick(9);
      chk("irq_on_fall", 32'(m_irq), 32'h1);
      m_gin[0] = 1'b1;
      tick(6);
      m_wr(ADDR_EDGE_CAP, 32'h01);
      chk("edge_vs_w1c_irq_a", 32'(m_irq), 32'h1);
      tick(1);
      chk("edge_vs_w1c_irq_b", 32'(m_irq), 32'h1);
      m_rd(ADDR_EDGE_CAP, 32'h01, "edge_wins_w1c");
      m_wr(ADDR_EDGE_CAP, 32'hFF);
      m_wr(ADDR_IRQ_MASK, 32'h0);
      tick(2);
      chk("irq_idle", 32'(m_irq), 32'h0);

      // Output latch and bus corner cases.
      m_wr(ADDR_DATA_OUT, 32'hA5);
      chk("data_out_write", 32'(m_gout), 32'hA5);
      m_wr(ADDR_OUT_SET, 32'h02);
      m_wr(ADDR_OUT_CLR, 32'h80);
      chk("set_clr_result", 32'(m_gout), 32'h27);
      m_rd(ADDR_DATA_OUT, 32'h27, "data_out_readback");
      m_rd(ADDR_OUT_SET,  32'h0,  "out_set_reads0");
      m_rd(ADDR_OUT_CLR,  32'h0,  "out_clr_reads0");
      m_rdwr(ADDR_DATA_OUT, 32'h3C, 32'h27, "rdwr_pre_write");
      m_rd(ADDR_DATA_OUT, 32'h3C, "rdwr_post_write");
      m_wr(ADDR_DATA_IN, 32'hFF);
      m_rd(ADDR_DATA_IN, 32'h01, "data_in_ro");
      m_wr(ADDR_RISE_EN, 32'hFFFF_FF00);
      m_rd(ADDR_RISE_EN, 32'h0, "wdata_high_ignored");

      // Reset in the middle of a debounce with edges captured.
      m_wr(ADDR_RISE_EN, 32'h03);
      m_wr(ADDR_FALL_EN, 32'h01);
      m_wr(ADDR_IRQ_MASK, 32'h01);
      m_gin = 8'b0000_0010;
      tick(10);
      m_rd(ADDR_EDGE_CAP, 32'h03, "cap_before_reset");
      chk("irq_before_reset", 32'(m_irq), 32'h1);
      m_gin[2] = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("midrst_gpio_out", 32'(m_gout), 32'h5A);
      chk("midrst_irq", 32'(m_irq), 32'h0);
      chk("midrst_readdata", m_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick(2);
      m_rd(ADDR_DATA_IN, 32'h0, "deb_restarts");
      tick(10);
      m_rd(ADDR_EDGE_CAP, 32'h0,  "no_edge_after_reset");
      m_rd(ADDR_DATA_IN,  32'h06, "data_in_after_reset");
      m_rd(ADDR_RISE_EN,  32'h0,  "rise_en_after_reset");
      m_rd(ADDR_FALL_EN,  32'h0,  "fall_en_after_reset");
      chk("irq_after_reset", 32'(m_irq), 32'h0);
      m_wr(ADDR_FALL_EN, 32'h04);
      m_gin[2] = 1'b0;
      tick(9);
      m_rd(ADDR_EDGE_CAP, 32'h04, "edge_after_reenable");

      tick(3);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avmm_gpio_bank.md
AVMM_GPIO_BANK -- requirements
Module: avmm_gpio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO bits (legal 1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles before an input change is accepted (0 = bypass).
REQ-003 SHALL have parameter OUT_RESET, default 0, reset value of gpio_out (WIDTH bits).
REQ-004 SHALL have port clk_clk  in  1  single clock domain; everything is clocked on its rising edge.
REQ-005 SHALL have port reset_reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port avs_address  in  3  word register index.
REQ-007 SHALL have port avs_read  in  1  read strobe.
REQ-008 SHALL have port avs_write  in  1  write strobe.
REQ-009 SHALL have port avs_writedata  in  32  write data.
REQ-010 SHALL have port avs_readdata  out  32  read data, fixed latency 1.
REQ-011 SHALL have port irq  out  1  level interrupt, registered.
REQ-012 SHALL have port gpio_in  in  WIDTH  asynchronous external inputs (buttons, switches).
REQ-013 SHALL have port gpio_out  out  WIDTH  registered outputs (LEDs).

Function
REQ-014 SHALL pass each gpio_in bit through a 2-flop synchroniser before any other use.
REQ-015 SHALL keep a per-bit debounced value that takes the synchronised value only after the two have differed for DEBOUNCE_CYCLES consecutive cycles; any cycle where they match restarts that bit's counter at 0.
REQ-016 SHALL, with DEBOUNCE_CYCLES=0, make the debounced value equal the synchronised value (2-cycle input latency).
REQ-017 SHALL size each debounce counter to clog2(DEBOUNCE_CYCLES+1) bits and never let it wrap.
REQ-018 SHALL use this register map: 0 DATA_IN (RO, debounced); 1 DATA_OUT (RW); 2 IRQ_MASK (RW); 3 EDGE_CAP (R, write-1-to-clear); 4 RISE_EN (RW); 5 FALL_EN (RW); 6 OUT_SET (WO, 1 bits set DATA_OUT); 7 OUT_CLR (WO, 1 bits clear DATA_OUT).
REQ-019 SHALL drive avs_readdata on the cycle after avs_read, with bits 31..WIDTH read as 0; write-only registers read 0.
REQ-020 SHALL set EDGE_CAP bit n on the cycle after debounced bit n goes 0->1 with RISE_EN[n]=1, or 1->0 with FALL_EN[n]=1.
REQ-021 SHALL let a new edge win over a write-1-to-clear of the same bit in the same cycle: the bit stays 1.
REQ-022 SHALL, when OUT_SET and OUT_CLR address the same bit in one write, apply only the addressed register's operation (one write per cycle).
REQ-023 SHALL register irq = OR over n of (EDGE_CAP[n] AND IRQ_MASK[n]), one cycle after either term changes.
REQ-024 SHALL ignore avs_writedata bits 31..WIDTH and ignore writes to address 0.
REQ-025 SHALL, when avs_read and avs_write are both asserted, perform both; read data reflects pre-write contents.

Reset
REQ-026 SHALL, on reset_reset_n low, asynchronously set gpio_out=OUT_RESET, IRQ_MASK=0, EDGE_CAP=0, RISE_EN=0, FALL_EN=0, irq=0, avs_readdata=0, counters=0, synchronisers and debounced values=0.
REQ-027 SHALL not record an edge when the first debounced update after reset moves a bit from 0 to 1 with RISE_EN=0 (the reset value); software enables edges after reset.
REQ-028 SHALL release reset synchronously by the system; mid-operation assertion aborts pending debounce counts and clears the captured edges.

Structure
REQ-029 SHALL put register offset constants (ADDR_DATA_IN..ADDR_OUT_CLR) in shared package gpio_bank_pkg.
REQ-030 SHALL implement the per-bit synchroniser+debounce as sub-module gpio_debounce, instantiated WIDTH times via generate.

Verification
REQ-031 SHALL cover: DEBOUNCE_CYCLES=4, gpio_in[0] 0->1 held -> DATA_IN[0]=1 exactly 2+4+1 cycles later; glitch of 3 cycles -> DATA_IN unchanged.
REQ-032 SHALL cover: RISE_EN=1, IRQ_MASK=1, bit 0 rises -> EDGE_CAP=0x01, irq=1 next cycle; write 0x01 to EDGE_CAP -> irq=0 one cycle later.
REQ-033 SHALL cover: edge arriving in the same cycle as a W1C to that bit -> EDGE_CAP bit stays 1, irq stays 1.
REQ-034 SHALL cover: write DATA_OUT=0xA5, OUT_SET=0x02, OUT_CLR=0x80 -> gpio_out=0x27; read DATA_OUT -> 0x00000027 one cycle after avs_read.
REQ-035 SHALL cover: WIDTH=2, write 0xFFFFFFFF to IRQ_MASK -> readback 0x00000003.
REQ-036 SHALL cover: reset asserted mid-debounce with EDGE_CAP=0x03 -> all outputs at reset values immediately, gpio_out=OUT_RESET, no edge after release until RISE_EN/FALL_EN are rewritten.
